imm_table: RTL

Parametrised, runtime-writable immediate table for the core's decode stage. It holds DEPTH immediates of W bits, loads a fixed default set after reset, serves NREAD independent registered lookups per cycle, and accepts single-entry updates over a valid/ready write port. It replaces the fixed combinational immediate lookup. Decode indexes it with the instruction's immediate field, and a debug/loader path can reprogram entries.

---
 rtl/imm_table.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/imm_table.sv
// Runtime-writable immediate table: loads a default set after reset, then serves
// NREAD registered lookups per cycle plus a valid/ready write port. Define
// IMM_TABLE_BYPASS_EN for write-first forwarding on a same-edge read/write hit.
module imm_table #(
   parameter int W     = 8,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH),
   parameter int NREAD = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [NREAD-1:0]    rd_en,
   input  logic [NREAD*AW-1:0] rd_index,
   output logic [NREAD*W-1:0]  rd_value,
   output logic [NREAD-1:0]    rd_valid,
   input  logic                wr_valid,
   input  logic [AW-1:0]       wr_index,
   input  logic [W-1:0]        wr_value,
   output logic                wr_ready,
   output logic                init_busy
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   state_t        state, next_state;
   logic [AW-1:0] init_cnt, next_cnt;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_data;
   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  rd_data [NREAD];

   function automatic logic in_range(input logic [AW-1:0] i);
      return {1'b0, i} < DEPTH_L;
   endfunction

   // Default contents are defined as 8-bit values, truncated or zero-extended to W.
   function automatic logic [W-1:0] default_val(input logic [AW-1:0] i);
      logic [7:0] d;
      d = 8'd0;
      case (32'(i))
         0, 1, 2, 3, 4, 5, 6: d = 8'(i);
         7:  d = 8'd14;
         8:  d = 8'd16;
         9:  d = 8'd30;
         10: d = 8'd31;
         11: d = 8'd32;
         12: d = 8'd33;
         13: d = 8'd60;
         14: d = 8'd91;
         15: d = 8'd109;
         16: d = 8'd142;
         17: d = 8'd170;
         18: d = 8'd204;
         19: d = 8'd224;
         20: d = 8'd225;
         21: d = 8'd240;
         22: d = 8'd247;
         23: d = 8'd254;
         24: d = 8'd85;
         25: d = 8'd171;
         26: d = 8'd90;
         default: d = 8'd0;
      endcase
      return W'(d);
   endfunction

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state    <= next_state;
         init_cnt <= next_cnt;
      end
   end

   // The table port is shared: INIT streams defaults, RUN takes host writes.
   always_comb begin
      next_state = state;
      next_cnt   = init_cnt;
      wr_ready   = 1'b0;
      init_busy  = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = init_cnt;
      mem_data   = default_val(init_cnt);
      case (state)
         INIT: begin
            init_busy = 1'b1;
            mem_we    = 1'b1;
            if (init_cnt == LAST) begin
               next_state = RUN;
               next_cnt   = '0;
            end else begin
               next_cnt = init_cnt + 1'b1;
            end
         end
         RUN: begin
            wr_ready = 1'b1;
            if (wr_valid && in_range(wr_index)) begin
               mem_we   = 1'b1;
               mem_addr = wr_index;
               mem_data = wr_value;
            end
         end
         default: next_state = INIT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (mem_we) mem[mem_addr] <= mem_data;
   end

   always_comb begin
      for (int p = 0; p < NREAD; p++) begin
         rd_data[p] = '0;
         if (in_range(rd_index[p*AW +: AW])) begin
            rd_data[p] = mem[rd_index[p*AW +: AW]];
`ifdef IMM_TABLE_BYPASS_EN
            if (state == RUN && wr_valid && wr_index == rd_index[p*AW +: AW])
               rd_data[p] = wr_value;
`else
`endif
         end
      end
   end

   // Idle ports keep their last value; only rd_valid drops.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rd_value <= '0;
         rd_valid <= '0;
      end else begin
         for (int p = 0; p < NREAD; p++) begin
            if (state == RUN && rd_en[p]) begin
               rd_valid[p]         <= 1'b1;
               rd_value[p*W +: W] <= rd_data[p];
            end else begin
               rd_valid[p] <= 1'b0;
            end
         end
      end
   end

endmodule
